// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: warm-up/run/pause/halt sequencer producing per-stage advance enables
module pipeline_sequencer #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STAGES-1:0]          stage_ready,
    input  logic                       flush,
    input  logic                       halt,
    output logic [STAGES-1:0]          stage_en,
    output logic [2:0]                 state_o,
    output logic [$clog2(STAGES)-1:0]  fill_o,
    output logic                       flush_ack,
    output logic [CNT_W-1:0]           stall_cycles
);
    localparam int FW = $clog2(STAGES);
    localparam logic [FW-1:0] LAST = FW'(STAGES - 2);
    localparam logic [STAGES-1:0] ONE = STAGES'(1);
    localparam logic [STAGES-1:0] TWO = STAGES'(2);

    typedef enum logic [2:0] {INIT = 3'd0, WARMUP = 3'd1, RUN = 3'd2, PAUSE = 3'd3, HALT = 3'd4} state_t;

    state_t state, state_n, saved, saved_n;
    logic [FW-1:0] fill, fill_n, saved_fill, saved_fill_n;
    logic ack_n;
    logic all_ready;

    assign all_ready = &stage_ready;
    assign state_o   = state;
    assign fill_o    = fill;

    // State, fill, saved pause context, flush acknowledge and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            fill         <= '0;
            saved        <= INIT;
            saved_fill   <= '0;
            flush_ack    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state        <= state_n;
            fill         <= fill_n;
            saved        <= saved_n;
            saved_fill   <= saved_fill_n;
            flush_ack    <= ack_n;
            stall_cycles <= (state == PAUSE && ~&stall_cycles) ? stall_cycles + 1'b1 : stall_cycles;
        end
    end

    // Next state: halt beats flush beats pause beats normal progression
    always_comb begin
        state_n      = state;
        fill_n       = fill;
        saved_n      = saved;
        saved_fill_n = saved_fill;
        ack_n        = 1'b0;
        if (halt && state != HALT) begin
            state_n = HALT;
        end else if (flush && (state == WARMUP || state == RUN || state == PAUSE)) begin
            state_n      = WARMUP;
            fill_n       = '0;
            saved_n      = INIT;
            saved_fill_n = '0;
            ack_n        = 1'b1;
        end else if (!all_ready && (state == INIT || state == WARMUP || state == RUN)) begin
            state_n      = PAUSE;
            saved_n      = state;
            saved_fill_n = fill;
        end else begin
            case (state)
                INIT: begin
                    state_n = WARMUP;
                    fill_n  = '0;
                end
                WARMUP: begin
                    state_n = (fill == LAST) ? RUN : WARMUP;
                    fill_n  = (fill == LAST) ? fill : fill + 1'b1;
                end
                PAUSE: begin
                    state_n = all_ready ? saved : PAUSE;
                    fill_n  = all_ready ? saved_fill : fill;
                end
                default: ;
            endcase
        end
    end

    // Enables decoded from registered state: stages 0..fill in warm-up, all in run
    always_comb begin
        stage_en = (state == WARMUP) ? (TWO << fill) - ONE : (state == RUN) ? '1 : '0;
    end
endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter STAGES, default 4, number of pipeline stages controlled (legal 2..16; stage 0 = fetch).
REQ-002 SHALL have parameter CNT_W, default 32, width of the stall-cycle counter.
REQ-003 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 stage_ready  input  STAGES  per-stage ready; any bit low requests a pipeline pause.
REQ-007 flush  input  1  redirect request (branch/jump); restarts fill from stage 0.
REQ-008 halt  input  1  stop request; sequencer parks until reset.
REQ-009 stage_en  output  STAGES  per-stage advance enable; bit k drives stage k.
REQ-010 state_o  output  3  current state: INIT=0, WARMUP=1, RUN=2, PAUSE=3, HALT=4.
REQ-011 fill_o  output  clog2(STAGES)  current warm-up fill index.
REQ-012 flush_ack  output  1  one-cycle pulse in the cycle after a flush is accepted.
REQ-013 stall_cycles  output  CNT_W  count of cycles spent in PAUSE since reset.

Function
REQ-014 INIT SHALL last exactly one cycle, then go to WARMUP with fill=0, unless halt or pause applies.
REQ-015 In WARMUP, stage_en[k] SHALL be 1 iff k <= fill; fill increments by 1 each unstalled cycle.
REQ-016 WARMUP with fill=STAGES-2 SHALL transition to RUN; fill holds at STAGES-2 in RUN.
REQ-017 In RUN, stage_en SHALL be all ones.
REQ-018 In INIT, PAUSE and HALT, stage_en SHALL be all zeros.
REQ-019 If any stage_ready bit is low in INIT, WARMUP or RUN, the next state SHALL be PAUSE; state and fill are saved, fill does not advance.
REQ-020 In PAUSE, the saved state/fill SHALL NOT be overwritten; when all stage_ready bits are high, the next state SHALL be the saved state with the saved fill.
REQ-021 Transition priority SHALL be: rst > halt > flush > pause > normal progression.
REQ-022 halt high in any non-HALT state SHALL move to HALT next cycle; HALT exits only on rst.
REQ-023 flush high in WARMUP, RUN or PAUSE SHALL move to WARMUP with fill=0 next cycle, clear the saved context, and assert flush_ack for that one cycle.
REQ-024 flush in INIT or HALT SHALL be ignored; flush_ack stays 0.
REQ-025 stall_cycles SHALL increment by 1 each cycle state_o=PAUSE and saturate at all ones, with no wrap.
REQ-026 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-027 rst high at a clock edge SHALL, regardless of other inputs:
- set state_o=INIT, fill_o=0, stage_en=0, flush_ack=0, stall_cycles=0;
- clear the saved context.
REQ-028 rst asserted mid-operation, including in PAUSE or HALT, SHALL take effect at the next edge with no residual saved context.

Verification
REQ-029 STAGES=4, all ready, no flush/halt, release rst:
- stage_en sequence SHALL be 0000, 0001, 0011, 0111, 1111, then 1111 held;
- state_o sequence SHALL be 0, 1, 1, 1, 2.
REQ-030 In WARMUP fill=1, stage_ready=1011 for 3 cycles:
- 3 cycles SHALL show state_o=3 and stage_en=0000;
- on resume, stage_en SHALL be 0011, then 0111;
- stall_cycles SHALL end at 3.
REQ-031 In RUN, flush=1 for one cycle:
- next cycle SHALL show stage_en=0001, fill_o=0, flush_ack=1;
- the following cycle SHALL show flush_ack=0 and stage_en=0011.
REQ-032 In PAUSE (saved RUN), assert flush and halt together -> next state_o=4, stage_en=0000, flush_ack=0, and the state is held until rst.
REQ-033 CNT_W=4, hold stage_ready[0]=0 for 20 cycles -> stall_cycles SHALL reach 15 and stay at 15.
REQ-034 STAGES=2, all ready -> stage_en sequence SHALL be 00, 01, 11, with RUN reached 2 cycles after reset release.
